// File: rtl/int_pkg.sv
// int_pkg: shared types and constants for the interrupt responder.
//   - int_state_e   : responder FSM state encoding
//   - INT_ID_*      : interrupt identifiers known to the controller
//   - INT_VEC_*     : default handler vector base
//   - vec_addr()    : handler entry address for an interrupt id
package int_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PENDING = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_ENTER   = 3'd3,
    ST_IN_ISR  = 3'd4,
    ST_RETURN  = 3'd5
  } int_state_e;

  localparam logic [31:0] INT_ID_SYSCALL       = 32'h0000_0000;
  localparam logic [31:0] INT_ID_BUTTON        = 32'h0000_0004;
  localparam logic [31:0] INT_VEC_BASE_DEFAULT = 32'h0000_4180;

  // Drain counter width; covers the legal DRAIN_CYCLES range 1..15.
  localparam int unsigned INT_DRAIN_W = 4;

  // Each handler vector slot is 16 bytes; the add wraps modulo 2^32.
  function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                           input logic [31:0] id);
    return base + (id << 4);
  endfunction

endpackage

// File: rtl/int_responder_if.sv
// int_responder_if: bundles the interrupt-controller / pipeline side of the
// responder.
//   requests  : start_int, int_id, pc_cur, instr_boundary, eret
//   responses : stall_req, pc_redirect, redirect_pc, epc, cause,
//               in_handler, RTI
// master = controller/pipeline side, slave = responder.
interface int_responder_if;
  logic        start_int;
  logic [31:0] int_id;
  logic [31:0] pc_cur;
  logic        instr_boundary;
  logic        eret;
  logic        stall_req;
  logic        pc_redirect;
  logic [31:0] redirect_pc;
  logic [31:0] epc;
  logic [31:0] cause;
  logic        in_handler;
  logic        RTI;

  modport master (
    output start_int, int_id, pc_cur, instr_boundary, eret,
    input  stall_req, pc_redirect, redirect_pc, epc, cause, in_handler, RTI
  );

  modport slave (
    input  start_int, int_id, pc_cur, instr_boundary, eret,
    output stall_req, pc_redirect, redirect_pc, epc, cause, in_handler, RTI
  );
endinterface

// File: rtl/int_drain_cnt.sv
// int_drain_cnt: pipeline-drain down-counter.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : load load_val (wins over dec)
//   dec        : decrement by one, saturating at zero
//   done       : registered, high while the count equals 1
module int_drain_cnt
  import int_pkg::*;
#(
  parameter int unsigned W = INT_DRAIN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // done is registered from the next count so it lines up with cnt_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      done  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      done  <= (cnt_d == W'(1));
    end
  end

endmodule

// File: rtl/int_responder.sv
// int_responder: single-level interrupt entry/exit sequencer.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : int_responder_if.slave (request inputs, registered outputs)
// Sequence: IDLE -> PENDING (wait for boundary) -> DRAIN (DRAIN_CYCLES)
// -> ENTER (redirect to vector) -> IN_ISR (until eret) -> RETURN (redirect
// to epc, RTI). Requests arriving while busy are held in one deferred slot.
module int_responder
  import int_pkg::*;
#(
  parameter logic [31:0] VEC_BASE     = INT_VEC_BASE_DEFAULT,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input logic             clk,
  input logic             rst_n,
  int_responder_if.slave  bus
);

  localparam int unsigned           DRAIN_W    = INT_DRAIN_W;
  localparam logic [DRAIN_W-1:0]    DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);

  int_state_e  state_q, state_d;
  logic [31:0] req_id_q, req_id_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        deferred_q, deferred_d;
  logic        stall_q, stall_d;
  logic        redirect_q, redirect_d;
  logic        in_handler_q, in_handler_d;
  logic        rti_q, rti_d;
  logic        drain_load, drain_dec, drain_done;

  int_drain_cnt #(.W(DRAIN_W)) u_drain_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (drain_load),
    .load_val (DRAIN_LOAD),
    .dec      (drain_dec),
    .done     (drain_done)
  );

  // Next state, captured context, and next values of the registered outputs.
  always_comb begin
    state_d       = state_q;
    req_id_d      = req_id_q;
    deferred_d    = deferred_q;
    epc_d         = epc_q;
    cause_d       = cause_q;
    redirect_pc_d = redirect_pc_q;
    drain_load    = 1'b0;
    drain_dec     = 1'b0;

    // Any request outside IDLE is deferred; the newest one wins.
    if (bus.start_int) begin
      req_id_d = bus.int_id;
      if (state_q != ST_IDLE) deferred_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start_int) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        if (bus.instr_boundary) begin
          epc_d      = bus.pc_cur;
          cause_d    = req_id_q;
          drain_load = 1'b1;
          state_d    = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        drain_dec = 1'b1;
        if (drain_done) state_d = ST_ENTER;
      end
      ST_ENTER: begin
        state_d = ST_IN_ISR;
      end
      ST_IN_ISR: begin
        if (bus.eret) state_d = ST_RETURN;
      end
      ST_RETURN: begin
        // A request arriving in this very cycle also counts as held.
        if (deferred_q || bus.start_int) begin
          deferred_d = 1'b0;
          state_d    = ST_PENDING;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are a function of the state being entered, then registered.
    stall_d      = (state_d == ST_PENDING) || (state_d == ST_DRAIN) ||
                   (state_d == ST_ENTER);
    redirect_d   = (state_d == ST_ENTER) || (state_d == ST_RETURN);
    in_handler_d = (state_d == ST_ENTER) || (state_d == ST_IN_ISR) ||
                   (state_d == ST_RETURN);
    rti_d        = (state_d == ST_RETURN);

    if (state_d == ST_ENTER) begin
      redirect_pc_d = vec_addr(VEC_BASE, cause_q);
    end else if (state_d == ST_RETURN) begin
      redirect_pc_d = epc_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      req_id_q      <= '0;
      deferred_q    <= 1'b0;
      epc_q         <= '0;
      cause_q       <= '0;
      redirect_pc_q <= '0;
      stall_q       <= 1'b0;
      redirect_q    <= 1'b0;
      in_handler_q  <= 1'b0;
      rti_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_id_q      <= req_id_d;
      deferred_q    <= deferred_d;
      epc_q         <= epc_d;
      cause_q       <= cause_d;
      redirect_pc_q <= redirect_pc_d;
      stall_q       <= stall_d;
      redirect_q    <= redirect_d;
      in_handler_q  <= in_handler_d;
      rti_q         <= rti_d;
    end
  end

  assign bus.stall_req   = stall_q;
  assign bus.pc_redirect = redirect_q;
  assign bus.redirect_pc = redirect_pc_q;
  assign bus.epc         = epc_q;
  assign bus.cause       = cause_q;
  assign bus.in_handler  = in_handler_q;
  assign bus.RTI         = rti_q;

endmodule

// File: tb/tb_int_responder.sv
// tb_int_responder: directed bench for int_responder with a timestamp-based
// reference model checked every cycle, plus literal expectations for the
// documented scenarios.
module tb_int_responder;
  import int_pkg::*;

  localparam int          D    = 3;
  localparam logic [31:0] VEC  = 32'h0000_4180;

  logic clk;
  logic rst_n;
  int_responder_if bus();

  int_responder #(.VEC_BASE(VEC), .DRAIN_CYCLES(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks the service as cycle timestamps: when the request became pending,
  // when the vector entry happens, and when the return happens.
  int          cyc = 0;
  int          t_pend = -1, t_enter = -1, t_ret = -1;
  bit          m_def = 0;
  logic [31:0] m_req = 0, m_epc = 0, m_cause = 0, m_rpc = 0;
  bit          e_stall = 0, e_redir = 0, e_inh = 0, e_rti = 0;

  always @(posedge clk) begin
    int c;
    int n;
    c = cyc;
    n = cyc + 1;
    cyc = n;
    if (!rst_n) begin
      t_pend = -1; t_enter = -1; t_ret = -1; m_def = 0;
      m_req = 0; m_epc = 0; m_cause = 0; m_rpc = 0;
    end else begin
      // boundary found while waiting: drain D cycles, then enter
      if (t_pend >= 0 && t_enter < 0 && bus.instr_boundary) begin
        t_enter = c + D + 1;
        m_epc   = bus.pc_cur;
        m_cause = m_req;
      end
      // eret only honoured while inside the handler body
      if (t_enter >= 0 && c >= t_enter + 1 && t_ret < 0 && bus.eret)
        t_ret = c + 1;
      if (t_ret >= 0 && c == t_ret) begin
        t_pend  = (m_def || bus.start_int) ? n : -1;
        if (bus.start_int) m_req = bus.int_id;
        m_def   = 0;
        t_enter = -1;
        t_ret   = -1;
      end else if (bus.start_int) begin
        m_req = bus.int_id;
        if (t_pend < 0) t_pend = n;
        else            m_def  = 1;
      end
    end
    e_stall = (t_pend >= 0) && (t_enter < 0 || n <= t_enter);
    e_redir = (t_enter >= 0 && n == t_enter) || (t_ret >= 0 && n == t_ret);
    e_inh   = (t_enter >= 0) && (n >= t_enter);
    e_rti   = (t_ret >= 0) && (n == t_ret);
    if (t_enter >= 0 && n == t_enter) m_rpc = VEC + m_cause * 32'd16;
    if (t_ret >= 0 && n == t_ret)     m_rpc = m_epc;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_stall_req",   {31'b0, bus.stall_req},   {31'b0, e_stall});
      chk("m_pc_redirect", {31'b0, bus.pc_redirect}, {31'b0, e_redir});
      chk("m_in_handler",  {31'b0, bus.in_handler},  {31'b0, e_inh});
      chk("m_RTI",         {31'b0, bus.RTI},         {31'b0, e_rti});
      chk("m_epc",   bus.epc,   m_epc);
      chk("m_cause", bus.cause, m_cause);
      if (e_redir) chk("m_redirect_pc", bus.redirect_pc, m_rpc);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_redirect(input int budget, output bit got);
    got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(posedge clk);
      #3;
      if (bus.pc_redirect === 1'b1) got = 1;
    end
    n_checks++;
    if (!got) begin
      n_errors++;
      $display("FAIL wait_redirect: pc_redirect stayed 0, required 1 within %0d cycles", budget);
    end
  endtask

  initial begin
    bit got;
    bus.start_int = 0; bus.int_id = 0; bus.pc_cur = 0;
    bus.instr_boundary = 0; bus.eret = 0;
    rst_n = 0;
    tick();
    chk_en = 1;
    tick();
    rst_n = 1;
    #2;
    chk("rst_stall", {31'b0, bus.stall_req}, 32'd0);
    chk("rst_redirect_pc", bus.redirect_pc, 32'd0);
    chk("rst_epc", bus.epc, 32'd0);

    // Button interrupt at a clean boundary, eret 10 cycles after entry.
    tick();
    bus.start_int = 1; bus.int_id = INT_ID_BUTTON;
    bus.pc_cur = 32'h0000_3000; bus.instr_boundary = 1;   // cycle N
    tick(); bus.start_int = 0;                            // N+1 pending
    repeat (3) tick();                                    // N+4 last drain
    bus.eret = 1;                                         // ignored in DRAIN
    tick(); bus.eret = 0;                                 // N+5
    #2;
    chk("s1_redirect",    {31'b0, bus.pc_redirect}, 32'd1);
    chk("s1_redirect_pc", bus.redirect_pc, 32'h0000_41C0);
    chk("s1_epc",         bus.epc, 32'h0000_3000);
    chk("s1_cause",       bus.cause, 32'h0000_0004);
    repeat (10) tick();
    bus.eret = 1;
    tick(); bus.eret = 0;                                 // RETURN
    #2;
    chk("s1_ret_redirect", {31'b0, bus.pc_redirect}, 32'd1);
    chk("s1_ret_pc",       bus.redirect_pc, 32'h0000_3000);
    chk("s1_rti",          {31'b0, bus.RTI}, 32'd1);
    tick();
    #2;
    chk("s1_idle_rti",     {31'b0, bus.RTI}, 32'd0);
    chk("s1_idle_handler", {31'b0, bus.in_handler}, 32'd0);
    chk("s1_epc_held",     bus.epc, 32'h0000_3000);
    bus.eret = 1;                                         // stray eret in IDLE
    tick(); bus.eret = 0;

    // Syscall while the pipeline is not at a boundary for 7 cycles.
    bus.instr_boundary = 0;
    tick();
    bus.start_int = 1; bus.int_id = INT_ID_SYSCALL; bus.pc_cur = 32'h0000_3100;
    tick(); bus.start_int = 0;
    for (int i = 0; i < 7; i++) begin
      #2;
      chk("s2_stall",       {31'b0, bus.stall_req}, 32'd1);
      chk("s2_no_redirect", {31'b0, bus.pc_redirect}, 32'd0);
      tick();
    end
    bus.instr_boundary = 1;
    wait_redirect(20, got);
    if (got) begin
      chk("s2_redirect_pc", bus.redirect_pc, 32'h0000_4180);
      chk("s2_epc",         bus.epc, 32'h0000_3100);
    end
    repeat (3) tick();
    bus.eret = 1;
    tick(); bus.eret = 0;
    #2;
    chk("s2_rti",    {31'b0, bus.RTI}, 32'd1);
    chk("s2_ret_pc", bus.redirect_pc, 32'h0000_3100);
    tick();

    // New request in the same handler cycle as eret: return, then re-enter.
    tick();
    bus.start_int = 1; bus.int_id = INT_ID_BUTTON; bus.pc_cur = 32'h0000_3200;
    tick(); bus.start_int = 0;
    wait_redirect(20, got);
    if (got) chk("s3_redirect_pc", bus.redirect_pc, 32'h0000_41C0);
    repeat (2) tick();
    bus.start_int = 1; bus.int_id = INT_ID_SYSCALL; bus.eret = 1;
    bus.pc_cur = 32'h0000_3300;
    tick(); bus.start_int = 0; bus.eret = 0;              // RETURN
    #2;
    chk("s3_rti",    {31'b0, bus.RTI}, 32'd1);
    chk("s3_ret_pc", bus.redirect_pc, 32'h0000_3200);
    tick();                                               // PENDING again
    #2;
    chk("s3_pend_stall",   {31'b0, bus.stall_req}, 32'd1);
    chk("s3_pend_handler", {31'b0, bus.in_handler}, 32'd0);
    wait_redirect(20, got);
    if (got) begin
      chk("s3_reenter_pc", bus.redirect_pc, 32'h0000_4180);
      chk("s3_cause",      bus.cause, 32'h0000_0000);
      chk("s3_epc",        bus.epc, 32'h0000_3300);
    end
    tick();
    bus.eret = 1;
    tick(); bus.eret = 0;
    #2;
    chk("s3_rti2", {31'b0, bus.RTI}, 32'd1);
    tick();

    // Reset during the second drain cycle abandons the interrupt.
    tick();
    bus.start_int = 1; bus.int_id = INT_ID_BUTTON; bus.pc_cur = 32'h0000_3400;
    tick(); bus.start_int = 0;                            // N+1 pending
    tick();                                               // N+2 drain 1
    tick();                                               // N+3 drain 2
    rst_n = 0;
    tick(); rst_n = 1;                                    // N+4
    #2;
    chk("s4_stall",    {31'b0, bus.stall_req}, 32'd0);
    chk("s4_redirect", {31'b0, bus.pc_redirect}, 32'd0);
    chk("s4_handler",  {31'b0, bus.in_handler}, 32'd0);
    chk("s4_rti",      {31'b0, bus.RTI}, 32'd0);
    chk("s4_epc",      bus.epc, 32'd0);
    chk("s4_cause",    bus.cause, 32'd0);
    chk("s4_rpc",      bus.redirect_pc, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick(); #2;
      chk("s4_quiet_rti", {31'b0, bus.RTI}, 32'd0);
    end
    bus.start_int = 1; bus.int_id = INT_ID_SYSCALL; bus.pc_cur = 32'h0000_3500;
    tick(); bus.start_int = 0;
    wait_redirect(20, got);
    if (got) begin
      chk("s4_redirect_pc", bus.redirect_pc, 32'h0000_4180);
      chk("s4_epc_new",     bus.epc, 32'h0000_3500);
    end
    repeat (2) tick();
    bus.eret = 1;
    tick(); bus.eret = 0;
    #2;
    chk("s4_rti_new", {31'b0, bus.RTI}, 32'd1);
    chk("s4_ret_pc",  bus.redirect_pc, 32'h0000_3500);
    repeat (3) tick();

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/int_responder.md
INT_RESPONDER -- requirements
Module: int_responder

Interface
REQ-001 Parameter VEC_BASE, default 32'h0000_4180, base address of handler vectors.
REQ-002 Parameter DRAIN_CYCLES, default 3, pipeline-flush cycles before redirect; legal range 1..15.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start_int  input  1  one-cycle interrupt request pulse from the interrupt controller.
REQ-006 int_id  input  32  interrupt identifier, valid with start_int; 0 = syscall, 4 = button.
REQ-007 pc_cur  input  32  PC of the oldest unretired instruction; this is the resume address.
REQ-008 instr_boundary  input  1  high when the pipeline is at a clean instruction boundary.
REQ-009 eret  input  1  high for one cycle when an ERET retires.
REQ-010 stall_req  output  1  tells the pipeline to stop fetching and issuing.
REQ-011 pc_redirect  output  1  one-cycle PC-load strobe.
REQ-012 redirect_pc  output  32  target PC; valid while pc_redirect is high.
REQ-013 epc  output  32  saved resume PC.
REQ-014 cause  output  32  int_id of the interrupt being serviced.
REQ-015 in_handler  output  1  high from ENTER through RETURN inclusive.
REQ-016 RTI  output  1  one-cycle return-from-interrupt pulse to the interrupt controller.

Function
REQ-017 FSM states: IDLE, PENDING, DRAIN, ENTER, IN_ISR, RETURN. All outputs are registered.
REQ-018 IDLE: when start_int=1, latch int_id into req_id and go to PENDING.
REQ-019 PENDING: assert stall_req.
- instr_boundary=1: epc<=pc_cur, cause<=req_id, load drain counter with DRAIN_CYCLES, go to DRAIN.
- otherwise: remain in PENDING.
REQ-020 DRAIN: assert stall_req; decrement the counter each cycle; go to ENTER in the cycle the counter reaches 1. DRAIN therefore lasts exactly DRAIN_CYCLES cycles.
REQ-021 ENTER (one cycle):
- pc_redirect=1, stall_req=1.
- redirect_pc = VEC_BASE + (cause << 4), 32-bit modulo-2^32 add.
- Next state IN_ISR.
REQ-022 IN_ISR: stall_req=0; remain until eret=1, then go to RETURN.
REQ-023 RETURN (one cycle): pc_redirect=1, redirect_pc=epc, RTI=1.
- Next state PENDING if a deferred request is held, else IDLE.
REQ-024 Latency: start_int in cycle N with instr_boundary held high gives pc_redirect in cycle N+2+DRAIN_CYCLES.
REQ-025 No nesting. A start_int seen in PENDING, DRAIN, ENTER, IN_ISR or RETURN:
- sets a single-entry deferred flag and stores its int_id in req_id;
- the latest such request overwrites any earlier one;
- the flag clears when PENDING is entered from RETURN.
REQ-026 start_int and eret in the same IN_ISR cycle: the return is taken and the request is deferred per REQ-025.
REQ-027 eret outside IN_ISR is ignored. RTI is never asserted outside RETURN.
REQ-028 epc and cause hold their values from capture until the next capture; they are not cleared on return.

Reset
REQ-029 rst_n=0 at a clock edge forces:
- state IDLE;
- stall_req, pc_redirect, RTI, in_handler = 0;
- redirect_pc, epc, cause, req_id, drain counter = 0;
- deferred flag = 0.
REQ-030 Reset in any state, including mid-DRAIN or IN_ISR, abandons the interrupt with no RTI pulse.

Structure
REQ-031 Package int_pkg holds:
- the FSM state encoding;
- ID constants INT_ID_SYSCALL=32'h0 and INT_ID_BUTTON=32'h4;
- the default VEC_BASE.
REQ-032 The drain counter is sub-module int_drain_cnt (load, decrement, done) and is instantiated once.

Verification
REQ-033 start_int with int_id=4 at pc_cur=32'h0000_3000, instr_boundary=1, DRAIN_CYCLES=3 -> pc_redirect at cycle N+5 with redirect_pc=32'h0000_41C0; epc=32'h0000_3000; cause=4.
REQ-034 Same as REQ-033, then eret 10 cycles later -> one-cycle pc_redirect with redirect_pc=32'h0000_3000 and RTI=1; state returns to IDLE.
REQ-035 start_int with id=0 while instr_boundary stays 0 for 7 cycles -> stall_req high throughout and no redirect; once instr_boundary=1, redirect_pc=32'h0000_4180.
REQ-036 start_int with id=0 in the same IN_ISR cycle as eret -> RTI pulse, then PENDING, then re-entry with cause=0.
REQ-037 rst_n=0 during the second DRAIN cycle -> all outputs 0 the next cycle, no RTI pulse, and a later start_int is serviced normally.
